// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: bus widths and FSM encodings.
package icache_pkg;

  localparam int WORD_W  = 32;
  localparam int LINE_W  = 128;
  localparam int PROC_AW = 30;
  localparam int MEM_AW  = 28;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: async read, single write port, sync valid clear.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX        = 3,
  parameter int TAG_W      = 25
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX-1:0]    widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [LINE_W-1:0] wline,
  input  logic [IDX-1:0]    ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [LINE_W-1:0] rline
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  // Clear wins over a same-cycle fill so a reset always leaves every line invalid.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wline;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rline  = data_q[ridx];

endmodule

// File: rtl/icache_direct.sv
// Read-only direct-mapped I-cache: hits served combinationally, misses stall and refill one
// 128-bit line over a request/ready handshake toward instruction memory.
module icache_direct
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int WORDS      = 4
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [PROC_AW-1:0] proc_addr,
  input  logic [WORD_W-1:0]  proc_wdata,
  output logic [WORD_W-1:0]  proc_rdata,
  output logic               proc_stall,
  output logic               mem_read,
  output logic               mem_write,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready
);

  localparam int IDX   = $clog2(NUM_BLOCKS);
  localparam int TAG_W = PROC_AW - 2 - IDX;

  logic [1:0]        state;
  logic              mem_read_q;
  logic [MEM_AW-1:0] mem_addr_q;

  logic [1:0]        off;
  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  tag;
  logic              line_vld;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_dat;
  logic              hit;
  logic              miss;
  logic              fill_we;

  assign off = proc_addr[1:0];
  assign idx = proc_addr[IDX+1:2];
  assign tag = proc_addr[PROC_AW-1:IDX+2];

  assign hit  = proc_read && line_vld && (line_tag == tag);
  assign miss = (state == S_IDLE) && proc_read && !hit;

  // Fill target comes from the latched block address, not the live proc_addr.
  assign fill_we = (state == S_FETCH) && mem_ready && !proc_reset;

  icache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX        (IDX),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk    (clk),
    .clr    (proc_reset),
    .we     (fill_we),
    .widx   (mem_addr_q[IDX-1:0]),
    .wtag   (mem_addr_q[MEM_AW-1:IDX]),
    .wline  (mem_rdata),
    .ridx   (idx),
    .rvalid (line_vld),
    .rtag   (line_tag),
    .rline  (line_dat)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= S_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            state      <= S_FETCH;
            mem_read_q <= 1'b1;
            mem_addr_q <= proc_addr[PROC_AW-1:2];
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            state      <= S_IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign proc_rdata = line_dat[{off, 5'b00000} +: WORD_W];
  assign proc_stall = !proc_reset && (miss || (state == S_FETCH));

  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  // Write-side inputs have no effect on a read-only cache.
  logic unused_wr;
  assign unused_wr = ^{proc_write, proc_wdata, WORDS[0]};

endmodule
